// File: rtl/split_sampler_pkg.sv
// Shared types and constants for the split_N candidate sampler.
package split_sampler_pkg;

   localparam logic [63:0] GOLDEN = 64'h9E3779B97F4A7C15;

   localparam int SH_A = 13;
   localparam int SH_B = 7;
   localparam int SH_C = 17;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HOLD = 2'd2,
      DONE = 2'd3
   } state_t;

   function automatic logic [63:0] xs64_step(input logic [63:0] x);
      logic [63:0] y;
      y = x ^ (x << SH_A);
      y = y ^ (y >> SH_B);
      y = y ^ (y << SH_C);
      return y;
   endfunction

   // A zero state would lock xorshift at zero forever.
   function automatic logic [63:0] lane_seed(input logic [63:0] s, input int k);
      logic [63:0] v;
      v = s ^ (64'(k) * GOLDEN);
      return (v == 64'd0) ? GOLDEN : v;
   endfunction

endpackage

// File: rtl/xorshift64_lane.sv
// One 64-bit xorshift generator lane with load and advance controls.
module xorshift64_lane
   import split_sampler_pkg::*;
(
   input  logic        clk,
   input  logic        load,
   input  logic [63:0] load_val,
   input  logic        adv,
   output logic [63:0] state
);

   always_ff @(posedge clk) begin
      if (load)
         state <= load_val;
      else if (adv)
         state <= xs64_step(state);
   end

endmodule

// File: rtl/split_sampler.sv
// Candidate generator and solution collector for a split_N checker.
module split_sampler
   import split_sampler_pkg::*;
#(
   parameter int VEC_W = 394,
   parameter int CNT_W = 32
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [63:0]      seed,
   input  logic [CNT_W-1:0] budget,
   input  logic             abort,
   output logic [VEC_W-1:0] cand,
   output logic             cand_valid,
   input  logic             sat,
   output logic [VEC_W-1:0] sol_data,
   output logic             sol_valid,
   input  logic             sol_ready,
   output logic [CNT_W-1:0] trials,
   output logic [CNT_W-1:0] hits,
   output logic             done,
   output logic             found
);

   localparam int LANES = (VEC_W + 63) / 64;
   localparam logic [CNT_W-1:0] ONE = 1;

   state_t state, state_n;
   logic [CNT_W-1:0] bud, trials_inc, hits_inc;
   logic [LANES*64-1:0] lanes;
   logic go, adv, done_n;

   assign go = start && !abort && (state == IDLE || state == DONE);
   assign trials_inc = (&trials) ? trials : trials + ONE;
   assign hits_inc = (&hits) ? hits : hits + ONE;

   assign cand = lanes[VEC_W-1:0];
   assign cand_valid = (state == RUN);
   assign sol_valid = (state == HOLD);

   // Reset loads zero so cand comes out of reset cleared.
   for (genvar k = 0; k < LANES; k++) begin : g_lane
      logic [63:0] lv;
      assign lv = rst ? 64'd0 : lane_seed(seed, k);
      xorshift64_lane u_lane (
         .clk      (clk),
         .load     (rst | go),
         .load_val (lv),
         .adv      (adv),
         .state    (lanes[k*64 +: 64])
      );
   end

   if (LANES * 64 > VEC_W) begin : g_pad
      logic unused_pad;
      assign unused_pad = ^lanes[LANES*64-1:VEC_W];
   end

   always_ff @(posedge clk) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_n;
   end

   always_comb begin
      state_n = state;
      adv = 1'b0;
      done_n = 1'b0;
      if (abort) begin
         state_n = IDLE;
      end else if (go) begin
         state_n = (budget == '0) ? DONE : RUN;
         done_n = (budget == '0);
      end else begin
         unique case (state)
            RUN: begin
               if (sat) begin
                  state_n = HOLD;
               end else if (trials_inc == bud) begin
                  state_n = DONE;
                  done_n = 1'b1;
               end else begin
                  adv = 1'b1;
               end
            end
            HOLD: begin
               if (sol_ready) begin
                  if (trials == bud) begin
                     state_n = DONE;
                     done_n = 1'b1;
                  end else begin
                     state_n = RUN;
                     adv = 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         trials <= '0;
         hits <= '0;
         found <= 1'b0;
         bud <= '0;
         sol_data <= '0;
         done <= 1'b0;
      end else begin
         done <= done_n;
         if (go) begin
            trials <= '0;
            hits <= '0;
            found <= 1'b0;
            bud <= budget;
         end else if (!abort && state == RUN) begin
            trials <= trials_inc;
            if (sat) begin
               hits <= hits_inc;
               found <= 1'b1;
               sol_data <= cand;
            end
         end
      end
   end

endmodule

// File: tb/tb_split_sampler.sv
// Directed self-checking bench for split_sampler.
module tb_split_sampler;

   localparam int VEC_W = 394;
   localparam int CNT_W = 32;
   localparam int LANES = (VEC_W + 63) / 64;
   localparam logic [63:0] GR = 64'h9E3779B97F4A7C15;

   logic clk = 1'b0;
   logic rst, start, abort, sat, sol_ready;
   logic [63:0] seed;
   logic [CNT_W-1:0] budget;
   logic [VEC_W-1:0] cand, sol_data;
   logic cand_valid, sol_valid, done, found;
   logic [CNT_W-1:0] trials, hits;
   logic [1:0] sat_mode;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   assign sat = (sat_mode == 2'd1) | ((sat_mode == 2'd2) & cand[0]);

   split_sampler #(.VEC_W(VEC_W), .CNT_W(CNT_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .seed       (seed),
      .budget     (budget),
      .abort      (abort),
      .cand       (cand),
      .cand_valid (cand_valid),
      .sat        (sat),
      .sol_data   (sol_data),
      .sol_valid  (sol_valid),
      .sol_ready  (sol_ready),
      .trials     (trials),
      .hits       (hits),
      .done       (done),
      .found      (found)
   );

   task automatic chk(input string tag, input logic [511:0] got,
                      input logic [511:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [63:0] xs(input logic [63:0] x);
      logic [63:0] y;
      y = x ^ (x << 13);
      y = y ^ (y >> 7);
      y = y ^ (y << 17);
      return y;
   endfunction

   function automatic logic [VEC_W-1:0] model(input logic [63:0] s, input int n);
      logic [LANES*64-1:0] v;
      logic [63:0] x;
      for (int k = 0; k < LANES; k++) begin
         x = s ^ (64'(k) * GR);
         if (x == 64'd0) x = GR;
         for (int i = 0; i < n; i++) x = xs(x);
         v[k*64 +: 64] = x;
      end
      return v[VEC_W-1:0];
   endfunction

   task automatic go(input logic [63:0] s, input logic [CNT_W-1:0] b);
      seed = s;
      budget = b;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic chk_reset(input string p);
      chk({p, "_cand"}, 512'(cand), 512'd0);
      chk({p, "_cvalid"}, 512'(cand_valid), 512'd0);
      chk({p, "_sdata"}, 512'(sol_data), 512'd0);
      chk({p, "_svalid"}, 512'(sol_valid), 512'd0);
      chk({p, "_trials"}, 512'(trials), 512'd0);
      chk({p, "_hits"}, 512'(hits), 512'd0);
      chk({p, "_done"}, 512'(done), 512'd0);
      chk({p, "_found"}, 512'(found), 512'd0);
   endtask

   logic [VEC_W-1:0] sols [8];
   logic [VEC_W-1:0] held_d;
   logic [CNT_W-1:0] held_t;
   int nsol, dcyc, nval, dups, zeros, moved, dseen;

   initial begin
      rst = 1'b1; start = 1'b0; abort = 1'b0; sol_ready = 1'b0;
      seed = '0; budget = '0; sat_mode = 2'd0;
      tick(); tick();
      chk_reset("por");
      rst = 1'b0;
      tick();

      // always-sat, budget 4
      sat_mode = 2'd1; sol_ready = 1'b1;
      go(64'h0123_4567_89AB_CDEF, 4);
      nsol = 0; dcyc = -1;
      for (int n = 0; n < 20 && dcyc < 0; n++) begin
         if (sol_valid && sol_ready && nsol < 8) begin
            sols[nsol] = sol_data;
            nsol++;
         end
         if (done) dcyc = n;
         else tick();
      end
      chk("t1_done_cyc", 512'(dcyc), 512'd8);
      chk("t1_nsol", 512'(nsol), 512'd4);
      dups = 0; zeros = 0;
      for (int i = 0; i < 4; i++) begin
         if (sols[i] == '0) zeros++;
         for (int j = i + 1; j < 4; j++)
            if (sols[i] == sols[j]) dups++;
      end
      chk("t1_dups", 512'(dups), 512'd0);
      chk("t1_zeros", 512'(zeros), 512'd0);
      for (int i = 0; i < 4; i++)
         chk($sformatf("t1_sol%0d", i), 512'(sols[i]),
             512'(model(64'h0123_4567_89AB_CDEF, i)));
      chk("t1_trials", 512'(trials), 512'd4);
      chk("t1_hits", 512'(hits), 512'd4);
      chk("t1_found", 512'(found), 512'd1);
      tick();
      chk("t1_done_pulse", 512'(done), 512'd0);

      // never-sat, budget 10
      sat_mode = 2'd0;
      go(64'hDEAD_BEEF_0000_0042, 10);
      nval = 0; dcyc = -1;
      for (int n = 0; n < 30 && dcyc < 0; n++) begin
         if (cand_valid) nval++;
         if (n == 3)
            chk("t2_cand3", 512'(cand), 512'(model(64'hDEAD_BEEF_0000_0042, 3)));
         if (done) dcyc = n;
         else tick();
      end
      chk("t2_nvalid", 512'(nval), 512'd10);
      chk("t2_done_cyc", 512'(dcyc), 512'd10);
      chk("t2_trials", 512'(trials), 512'd10);
      chk("t2_hits", 512'(hits), 512'd0);
      chk("t2_found", 512'(found), 512'd0);

      // sat = cand[0], backpressure, then abort in HOLD
      sat_mode = 2'd2; sol_ready = 1'b0;
      go(64'd1, 100);
      dseen = 0;
      for (int n = 0; n < 50 && !sol_valid; n++) tick();
      chk("t3_svalid", 512'(sol_valid), 512'd1);
      chk("t3_sdata", 512'(sol_data), 512'(model(64'd1, 0)));
      chk("t3_bit0", 512'(sol_data[0]), 512'd1);
      held_d = sol_data; held_t = trials; moved = 0;
      for (int n = 0; n < 5; n++) begin
         tick();
         if (sol_data !== held_d || trials !== held_t || !sol_valid) moved++;
      end
      chk("t3_stable", 512'(moved), 512'd0);
      chk("t3_trials", 512'(trials), 512'd1);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("t4_svalid", 512'(sol_valid), 512'd0);
      chk("t4_cvalid", 512'(cand_valid), 512'd0);
      chk("t4_trials_kept", 512'(trials), 512'd1);
      for (int n = 0; n < 5; n++) begin
         if (done) dseen++;
         tick();
      end
      chk("t4_no_done", 512'(dseen), 512'd0);
      chk("t4_idle", 512'(cand_valid), 512'd0);
      sat_mode = 2'd0;
      go(64'h55, 3);
      chk("t4_trials_clr", 512'(trials), 512'd0);
      chk("t4_hits_clr", 512'(hits), 512'd0);
      chk("t4_found_clr", 512'(found), 512'd0);
      chk("t4_cvalid_run", 512'(cand_valid), 512'd1);
      for (int n = 0; n < 10 && !done; n++) tick();
      chk("t4_done", 512'(done), 512'd1);

      // seed 0: lane 0 replaced by the golden constant
      go(64'd0, 1000);
      chk("t5_lane0", 512'(cand[63:0]), 512'(GR));
      zeros = 0; nval = 0; dcyc = -1;
      for (int n = 0; n < 1100 && dcyc < 0; n++) begin
         if (cand_valid) begin
            nval++;
            if (cand == '0) zeros++;
         end
         if (done) dcyc = n;
         else tick();
      end
      chk("t5_zeros", 512'(zeros), 512'd0);
      chk("t5_nvalid", 512'(nval), 512'd1000);
      chk("t5_trials", 512'(trials), 512'd1000);

      // budget 0, then reset mid-run
      go(64'h77, 0);
      chk("t6_done", 512'(done), 512'd1);
      chk("t6_found", 512'(found), 512'd0);
      chk("t6_cvalid", 512'(cand_valid), 512'd0);
      tick();
      chk("t6_done_pulse", 512'(done), 512'd0);
      sat_mode = 2'd0;
      go(64'h99, 100);
      for (int n = 0; n < 5; n++) tick();
      chk("t6_running", 512'(trials), 512'd5);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk_reset("rst");
      tick();
      chk("rst_idle", 512'(cand_valid), 512'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/split_sampler.md
# split_sampler

Sequential candidate generator and solution collector that sits directly upstream of a `split_N` constraint checker. It drives one pseudo-random assignment of all checker variables per cycle, samples the checker's combinational `x` result, and hands satisfying assignments downstream over a valid/ready port. It also keeps trial and hit counts for the solver's statistics path.

## Interface
- `VEC_W`, 394: packed candidate width, equal to the sum of the checker's variable widths (394 for `split_2`), var_0 in the LSBs.
- `CNT_W`, 32: width of the budget, trial and hit counters.
- `LANES`, ceil(VEC_W/64): number of 64-bit generator lanes (derived, not overridden).
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: pulse that begins a run; accepted only in IDLE or DONE.
- `seed` in 64: run seed, sampled on an accepted `start`.
- `budget` in CNT_W: maximum number of trials, sampled on an accepted `start`.
- `abort` in 1: ends any run and returns the block to IDLE.
- `cand` out VEC_W: registered candidate assignment, wired to the checker inputs.
- `cand_valid` out 1: `cand` is a live trial this cycle.
- `sat` in 1: checker `x`, combinational from `cand`.
- `sol_data` out VEC_W: captured satisfying assignment.
- `sol_valid` out 1, `sol_ready` in 1: downstream handshake.
- `trials`, `hits` out CNT_W: counts for the current or last run.
- `done` out 1: one-cycle pulse when the run ends.
- `found` out 1: at least one hit in the last run; held until the next accepted `start`.

## Operation
- States:
  - IDLE: entered from reset or `abort`.
  - RUN: issuing trials.
  - HOLD: a solution is pending on the output port.
  - DONE: run ended.
- Accepted `start`:
  - Loads lane k with `seed ^ (k * 64'h9E3779B97F4A7C15)`. A result of zero is replaced by `64'h9E3779B97F4A7C15`.
  - Clears `trials`, `hits` and `found`, latches `budget`.
  - Next state is RUN, or DONE if `budget == 0`.
- Each lane is xorshift64 (<<13, >>7, <<17). `cand` is the concatenation of the lane states, lane 0 in the LSBs, truncated to VEC_W.
- In RUN, every cycle:
  - `cand_valid` = 1 and `trials` increments.
  - If `sat` = 1: capture `cand` into `sol_data`, increment `hits`, set `found`, go to HOLD.
  - Else, if the incremented `trials == budget`: go to DONE.
  - Else: advance all lanes and stay in RUN.
- In HOLD:
  - `cand_valid` = 0, and lanes and counters are frozen.
  - `sol_valid` = 1. `sol_data` stays stable until `sol_ready`.
  - On the handshake: go to DONE if `trials == budget`, else advance the lanes and go to RUN.
- DONE: `done` pulses on entry and the state is held until `start` or `abort`.
- `abort` has priority over `start` in the same cycle. It drops `sol_valid` immediately (the pending solution is discarded) and keeps the counters.
- Counters saturate at all-ones; they never wrap.

## Timing
- Reset values: state IDLE, `cand` 0, `cand_valid` 0, `sol_data` 0, `sol_valid` 0, `trials` 0, `hits` 0, `done` 0, `found` 0.
- `start` at edge t: first candidate on `cand` with `cand_valid` after edge t; `sat` is evaluated in that cycle.
- Hit at cycle c:
  - `sol_valid` is high from cycle c+1.
  - With `sol_ready` held high, the next trial issues at c+2, giving a one-cycle bubble per hit.
- Sustained throughput without hits: one trial per cycle.
- Last trial of the budget is a hit: the solution is delivered first, and `done` pulses in the cycle after the handshake.
- `budget == 0`: `done` pulses one cycle after `start`, with `found` = 0.
- `rst` mid-run has the same effect as power-on reset. `sol_valid` is low in the cycle following reset.

## Structure
- Shared package `split_sampler_pkg`:
  - `GOLDEN` constant (`64'h9E3779B97F4A7C15`).
  - State enum.
  - Lane shift constants.
- One sub-module `xorshift64_lane`:
  - Ports: `clk`, `load`, `load_val`, `adv`, `state`.
  - Instanced LANES times through a generate loop.

## Test plan
- `sat` tied to 1, budget 4, `sol_ready` = 1: four solutions, each a distinct nonzero value; `trials` = 4, `hits` = 4; `done` 8 cycles after `start`; `found` = 1.
- `sat` tied to 0, budget 10: `cand_valid` high for exactly 10 cycles; `done` on the 11th; `hits` = 0, `found` = 0.
- `sat` = `cand[0]`, seed 1, `sol_ready` low for 5 cycles after the first hit: `sol_data` and `trials` stable throughout; `sol_data[0]` = 1.
- `seed` = 0 with lane 0 forced to zero: lane 0 initial state = `GOLDEN`; `cand` never all-zero over 1000 trials.
- `abort` asserted during HOLD: next cycle `sol_valid` = 0 and state IDLE; no `done` pulse; a later `start` restarts with cleared counters.
- `budget` = 0, then `rst` asserted during a 100-trial run: `done` one cycle after `start`; after reset all outputs match the reset values.
